// File: rtl/three_bit_divider.sv
// Sequential restoring divider: 6-bit dividend by 3-bit divisor, one quotient bit per cycle.
// Optional macro DIV_ZERO_DETECT_EN adds the div_zero port and a one-cycle divide-by-zero shortcut.
module three_bit_divider (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] dividend,
    input  logic [2:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [5:0] quotient,
    output logic [2:0] remainder
`ifdef DIV_ZERO_DETECT_EN
    ,
    output logic       div_zero
`endif
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t     state, state_next;
    logic [5:0] dvd_q;
    logic [2:0] dvs_q;
    logic [3:0] pr_q;
    logic [5:0] q_work;
    logic [2:0] iter_q;

    logic       accept;
    logic       zero_skip;
    logic       last_iter;
    logic       q_bit;
    logic [3:0] shifted;
    logic [3:0] pr_next;

    always_comb begin
        accept    = start && ((state == IDLE) || (state == DONE));
`ifdef DIV_ZERO_DETECT_EN
        zero_skip = accept && (divisor == 3'd0);
`else
        zero_skip = 1'b0;
`endif
        // Shift truncates to the 4-bit partial remainder; divisor 0 always "subtracts" nothing.
        shifted   = 4'({pr_q, dvd_q[5]});
        q_bit     = (shifted >= {1'b0, dvs_q});
        pr_next   = q_bit ? (shifted - {1'b0, dvs_q}) : shifted;
        last_iter = (iter_q == 3'd5);
        busy      = (state == CALC);
        done      = (state == DONE);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = zero_skip ? DONE : CALC;
            CALC: if (last_iter) state_next = DONE;
            DONE: begin
                if (accept) state_next = zero_skip ? DONE : CALC;
                else        state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dvd_q     <= '0;
            dvs_q     <= '0;
            pr_q      <= '0;
            q_work    <= '0;
            iter_q    <= '0;
            quotient  <= '0;
            remainder <= '0;
`ifdef DIV_ZERO_DETECT_EN
            div_zero  <= 1'b0;
`endif
        end else if (accept) begin
            dvd_q  <= dividend;
            dvs_q  <= divisor;
            pr_q   <= '0;
            q_work <= '0;
            iter_q <= '0;
`ifdef DIV_ZERO_DETECT_EN
            if (zero_skip) begin
                quotient  <= '1;
                remainder <= dividend[2:0];
                div_zero  <= 1'b1;
            end
`endif
        end else if (state == CALC) begin
            dvd_q  <= 6'({dvd_q, 1'b0});
            pr_q   <= pr_next;
            q_work <= 6'({q_work, q_bit});
            iter_q <= iter_q + 3'd1;
            if (last_iter) begin
                quotient  <= 6'({q_work, q_bit});
                remainder <= pr_next[2:0];
`ifdef DIV_ZERO_DETECT_EN
                div_zero  <= 1'b0;
`endif
            end
        end
    end

endmodule
